// File: rtl/cpu_icache_pkg.sv
// cpu_icache_pkg: FSM state type and address-field width helpers for cpu_icache_dm.
package cpu_icache_pkg;
  typedef enum logic [1:0] {IDLE, COMPARE, REFILL, RESPOND} state_t;
  function automatic int ofs_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction
  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction
  function automatic int tag_w(input int addr_width, input int line_words, input int num_lines);
    return addr_width - ofs_w(line_words) - index_w(num_lines);
  endfunction
endpackage

// File: rtl/cpu_icache_ram.sv
// cpu_icache_ram: synchronous-read RAM, one write port and one registered read port.
// Ports: clock; we/waddr/wdata write; re/raddr read request; rdata valid the cycle after re.
module cpu_icache_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/cpu_icache_dm.sv
// cpu_icache_dm: direct-mapped instruction cache with one-cycle hits and burst line refill.
// Ports: clock, reset (async, active-low); CPU side cpui_request/cpui_addr -> cpui_ack/cpui_rdata;
// flush pulse invalidates all lines; memory side mem_request/mem_addr -> mem_rvalid/mem_rdata beats.
// Optional macro CPU_ICACHE_STATS_EN adds stat_hits/stat_misses counters.
module cpu_icache_dm
  import cpu_icache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpui_request,
  input  logic [ADDR_WIDTH-1:0] cpui_addr,
  output logic [31:0]           cpui_rdata,
  output logic                  cpui_ack,
  input  logic                  flush,
  output logic                  mem_request,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rvalid
`ifdef CPU_ICACHE_STATS_EN
  ,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses
`endif
);
  localparam int OFS = ofs_w(LINE_WORDS);
  localparam int OW  = OFS - 2;
  localparam int IW  = index_w(NUM_LINES);
  localparam int TW  = tag_w(ADDR_WIDTH, LINE_WORDS, NUM_LINES);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:2] addr_q;
  logic [TW-1:0] tag_q, tag_rd;
  logic [IW-1:0] idx_q;
  logic [OW-1:0] off_q, beat;
  logic [31:0] data_rd, resp_q;
  logic [NUM_LINES-1:0] valid;
  logic flush_pending, hit, lookup, beat_we, last_beat, unused_addr_lsb;
  assign unused_addr_lsb = ^cpui_addr[1:0];
  assign tag_q = addr_q[ADDR_WIDTH-1:OFS];
  assign idx_q = addr_q[OFS+IW-1:OFS];
  assign off_q = addr_q[OFS-1:2];
  assign lookup = state == IDLE && cpui_request;
  assign hit = valid[idx_q] && tag_rd == tag_q;
  assign beat_we = state == REFILL && mem_rvalid;
  assign last_beat = beat_we && &beat;
  cpu_icache_ram #(.DEPTH(NUM_LINES * LINE_WORDS), .WIDTH(32)) u_data (
    .clock(clock), .we(beat_we), .waddr({idx_q, beat}), .wdata(mem_rdata),
    .re(lookup), .raddr(cpui_addr[OFS+IW-1:2]), .rdata(data_rd)
  );
  cpu_icache_ram #(.DEPTH(NUM_LINES), .WIDTH(TW)) u_tag (
    .clock(clock), .we(last_beat), .waddr(idx_q), .wdata(tag_q),
    .re(lookup), .raddr(cpui_addr[OFS+IW-1:OFS]), .rdata(tag_rd)
  );
  always_comb begin
    state_n = state;
    cpui_ack = 1'b0;
    cpui_rdata = '0;
    mem_request = 1'b0;
    mem_addr = '0;
    case (state)
      IDLE: state_n = cpui_request ? COMPARE : IDLE;
      COMPARE: begin
        state_n = hit ? IDLE : REFILL;
        cpui_ack = hit;
        cpui_rdata = data_rd;
        mem_request = !hit;
        mem_addr = hit ? '0 : {addr_q[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
      end
      REFILL: state_n = last_beat ? RESPOND : REFILL;
      RESPOND: begin
        state_n = IDLE;
        cpui_ack = 1'b1;
        cpui_rdata = resp_q;
      end
      default: state_n = IDLE;
    endcase
  end
  // A flush seen while busy is deferred until the ack has gone out, so it also
  // wipes the line that was just refilled; in IDLE it beats a same-cycle lookup.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      flush_pending <= 1'b0;
      valid <= '0;
      beat <= '0;
    end else begin
      state <= state_n;
      flush_pending <= state != IDLE && (flush_pending || flush);
      if (state == IDLE && (flush || flush_pending)) valid <= '0;
      else if (last_beat) valid[idx_q] <= 1'b1;
      beat <= state == COMPARE ? '0 : beat + OW'(beat_we);
    end
  end
  always_ff @(posedge clock) begin
    if (lookup) addr_q <= cpui_addr[ADDR_WIDTH-1:2];
    if (beat_we && beat == off_q) resp_q <= mem_rdata;
  end
`ifdef CPU_ICACHE_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_hits <= '0;
      stat_misses <= '0;
    end else if (state == COMPARE) begin
      if (hit) stat_hits <= stat_hits + 32'd1;
      else stat_misses <= stat_misses + 32'd1;
    end
  end
`endif
`ifndef SYNTHESIS
  a_req_in_idle: assert property (@(posedge clock) disable iff (!reset) cpui_request |-> state == IDLE)
    else $error("cpui_request issued while cache busy");
`endif
endmodule
